dep_scoreboard: RTL and testbench
=================================

Name: dep_scoreboard

Overview:
Data-dependence controller for the 5-stage pipelined CPU. It tracks destination registers of in-flight instructions in EX, MEM and WB, raises a one-cycle stall for load-use hazards, and drives operand-forwarding selects for the instruction in EX. It sits beside the IF/ID register, driven by the decoded ID instruction. It steers the datapath so that dependent back-to-back instructions produce correct register values.

Parameters:
NREG, 16, architectural register count (R0 hardwired zero)
IW, 16, instruction width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
id_instr  input  IW  instruction currently in ID
id_valid  input  1  ID instruction is real (0 = bubble)
flush  input  1  taken branch/CALL/RET in EX; kill ID instruction
stall  output  1  hold PC and IF/ID, inject bubble into EX (combinational)
fwd_a  output  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b  output  2  EX operand B select, same encoding
ex_src_a  output  4  registered A-source of EX instruction (debug/visibility)
ex_src_b  output  4  registered B-source of EX instruction

Behaviour:
- Decode: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- Ops 0000-0111 (ALU): read rs->A, rt->B; write rd.
- LW 1000: read rs->A; write rd; flagged load.
- SW 1001: read rs->A, rd->B; no write.
- LHB 1010: read rd->A; write rd. LLB 1011: no reads; write rd.
- B 1100, HLT 1111: no reads, no write. CALL 1101: write R15. RET 1110: read R15->A.
- Unused source fields are recorded as 0 (never match).
- State: three slots EX, MEM, WB, each {valid, dest[3:0], wr, is_load, srcA, srcB}.
- Each cycle: WB<=MEM, MEM<=EX. EX<=decoded ID instruction, except that EX<=bubble (valid=0) when stall=1, flush=1, or id_valid=0.
- stall = id_valid & !flush & EX.valid & EX.is_load & EX.dest!=0 & (EX.dest==ID srcA | EX.dest==ID srcB), for used sources only.
- A stall lasts exactly one cycle per load-use pair. Afterwards the load is in MEM and is covered by forwarding.
- fwd_a: 01 if MEM.valid & MEM.wr & MEM.dest!=0 & MEM.dest==EX.srcA; else 10 if WB satisfies the same test; else 00. MEM has priority over WB. fwd_b is computed the same way on srcB.
- fwd_* are zero whenever EX.valid=0.
- Writes to R0 are never forwarded or stalled on.
- WB-to-ID same-cycle dependence is handled by register-file write-before-read and is not this block's concern.
- flush and stall simultaneously: flush wins, stall=0, EX<=bubble.
- Reset: all slots invalid, stall=0, fwd_a=fwd_b=00, ex_src_*=0. Reset asserted mid-stall clears the stall on the next edge.

Test Plan:
- Load-use: LW R1,R2,0 then ADD R3,R1,R4 -> stall=1 for exactly 1 cycle with the ADD in ID; then ADD in EX with fwd_a=10 (load in WB... via MEM/WB).
- ALU chain: ADD R1,R2,R3; SUB R4,R1,R1 -> no stall; SUB in EX gives fwd_a=01, fwd_b=01.
- Distance 2 with priority: ADD R1,..; ADD R1,..; ADD R5,R1,R6 -> fwd_a=01 (nearest writer wins, not 10).
- R0 target: LW R0,R2,0 then ADD R3,R0,R0 -> stall=0, fwd_a=fwd_b=00.
- Flush: LW R1 in EX, flush=1 with dependent ADD R3,R1,R1 in ID -> stall=0; next cycle EX.valid=0, fwd=00.
- CALL/RET and SW: CALL then RET -> RET in EX gets fwd_a=01 (R15). LW R7 then SW R7,R2,0 -> stall 1 cycle on B source.
- Reset mid-stall: assert rst during the stall cycle -> next edge stall=0, all fwd=00, ex_src=0.

Source files
------------

// File: rtl/dep_scoreboard_if.sv
// Handshake bundle between the ID stage and the dependence scoreboard:
// decoded-instruction inputs in, stall/forwarding controls out.
interface dep_scoreboard_if #(
    parameter int IW = 16,
    parameter int RW = 4
);
    logic [IW-1:0] id_instr;
    logic          id_valid;
    logic          flush;
    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [RW-1:0] ex_src_a;
    logic [RW-1:0] ex_src_b;

    modport master (
        output id_instr, id_valid, flush,
        input  stall, fwd_a, fwd_b, ex_src_a, ex_src_b
    );

    modport slave (
        input  id_instr, id_valid, flush,
        output stall, fwd_a, fwd_b, ex_src_a, ex_src_b
    );
endinterface

// File: rtl/dep_scoreboard.sv
// Data-dependence controller for the 5-stage pipeline: tracks EX/MEM/WB
// destinations, stalls on load-use, and selects operand forwarding for EX.
module dep_scoreboard #(
    parameter int NREG = 16,
    parameter int IW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dep_scoreboard_if.slave  bus
);
    localparam int RW = $clog2(NREG);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dest;
        logic          wr;
        logic          isLoad;
        logic [RW-1:0] srcA;
        logic [RW-1:0] srcB;
    } slot_t;

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d;
    slot_t idDec;

    logic [3:0]    op;
    logic [RW-1:0] rdF, rsF, rtF;
    logic          loadUse;
    logic          stallInt;

    assign op  = bus.id_instr[15:12];
    assign rdF = bus.id_instr[8 +: RW];
    assign rsF = bus.id_instr[4 +: RW];
    assign rtF = bus.id_instr[0 +: RW];

    // Unused source fields stay zero so they can never match a real writer.
    always_comb begin
        idDec       = '0;
        idDec.valid = 1'b1;
        casez (op)
            4'b0???: begin
                idDec.srcA = rsF;
                idDec.srcB = rtF;
                idDec.dest = rdF;
                idDec.wr   = 1'b1;
            end
            4'b1000: begin
                idDec.srcA   = rsF;
                idDec.dest   = rdF;
                idDec.wr     = 1'b1;
                idDec.isLoad = 1'b1;
            end
            4'b1001: begin
                idDec.srcA = rsF;
                idDec.srcB = rdF;
            end
            4'b1010: begin
                idDec.srcA = rdF;
                idDec.dest = rdF;
                idDec.wr   = 1'b1;
            end
            4'b1011: begin
                idDec.dest = rdF;
                idDec.wr   = 1'b1;
            end
            4'b1101: begin
                idDec.dest = '1;
                idDec.wr   = 1'b1;
            end
            4'b1110: begin
                idDec.srcA = '1;
            end
            default: ;
        endcase
    end

    always_comb begin
        loadUse = ex_q.valid && ex_q.isLoad && (ex_q.dest != '0) &&
                  ((ex_q.dest == idDec.srcA) || (ex_q.dest == idDec.srcB));
        stallInt = bus.id_valid && !bus.flush && loadUse;
        ex_d = '0;
        if (bus.id_valid && !bus.flush && !stallInt) begin
            ex_d = idDec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Nearest writer wins: MEM result is younger than WB result.
    function automatic logic [1:0] fwdSel(input slot_t ex, input slot_t mem,
                                          input slot_t wb, input logic [RW-1:0] src);
        fwdSel = 2'b00;
        if (ex.valid) begin
            if (mem.valid && mem.wr && (mem.dest != '0) && (mem.dest == src)) begin
                fwdSel = 2'b01;
            end else if (wb.valid && wb.wr && (wb.dest != '0) && (wb.dest == src)) begin
                fwdSel = 2'b10;
            end
        end
    endfunction

    assign bus.stall    = stallInt;
    assign bus.fwd_a    = fwdSel(ex_q, mem_q, wb_q, ex_q.srcA);
    assign bus.fwd_b    = fwdSel(ex_q, mem_q, wb_q, ex_q.srcB);
    assign bus.ex_src_a = ex_q.srcA;
    assign bus.ex_src_b = ex_q.srcB;
endmodule

// File: tb/tb_dep_scoreboard.sv
// Self-checking bench for dep_scoreboard: per-cycle vectors with expected
// stall/forward/source values queued at drive time and compared before the edge.
module tb_dep_scoreboard;
    logic clk;
    logic rst;

    dep_scoreboard_if #(.IW(16), .RW(4)) bus ();

    dep_scoreboard #(.NREG(16), .IW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstV;
        logic        vld;
        logic        fl;
        logic [15:0] instr;
        logic        expStall;
        logic [1:0]  expFwdA;
        logic [1:0]  expFwdB;
        logic [3:0]  expSrcA;
        logic [3:0]  expSrcB;
        string       name;
    } vec_t;

    vec_t expQ[$];
    vec_t vecs[$];
    vec_t hand[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic f,
                                input logic [15:0] i, input logic st,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [3:0] sa, input logic [3:0] sb,
                                input string n);
        vec_t x;
        x.rstV = r; x.vld = v; x.fl = f; x.instr = i;
        x.expStall = st; x.expFwdA = fa; x.expFwdB = fb;
        x.expSrcA = sa; x.expSrcB = sb; x.name = n;
        return x;
    endfunction

    task automatic cmp(input string n, input string field,
                       input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", n, field, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst          = v.rstV;
        bus.id_valid = v.vld;
        bus.flush    = v.fl;
        bus.id_instr = v.instr;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = expQ.pop_front();
        cmp(e.name, "stall", {3'b0, bus.stall}, {3'b0, e.expStall});
        cmp(e.name, "fwd_a", {2'b0, bus.fwd_a}, {2'b0, e.expFwdA});
        cmp(e.name, "fwd_b", {2'b0, bus.fwd_b}, {2'b0, e.expFwdB});
        cmp(e.name, "ex_src_a", bus.ex_src_a, e.expSrcA);
        cmp(e.name, "ex_src_b", bus.ex_src_b, e.expSrcB);
    endtask

    task automatic runStep(input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        // rst vld fl instr              st fa fb sa sb
        vecs.push_back(mk(0,0,0,16'h0000,        0,0,0,0,0,  "reset"));
        vecs.push_back(mk(0,1,0,ins(8,1,2,0),    0,0,0,0,0,  "lw_issue"));
        vecs.push_back(mk(0,1,0,ins(0,3,1,4),    1,0,0,2,0,  "lu_stall"));
        vecs.push_back(mk(0,1,0,ins(0,3,1,4),    0,0,0,0,0,  "lu_bubble"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,2,0,1,4,  "lu_fwd"));
        vecs.push_back(mk(0,1,0,ins(0,1,2,3),    0,0,0,0,0,  "alu1"));
        vecs.push_back(mk(0,1,0,ins(1,4,1,1),    0,0,2,2,3,  "alu2"));
        vecs.push_back(mk(0,1,0,ins(0,1,5,6),    0,1,1,1,1,  "chain_fwd"));
        vecs.push_back(mk(0,1,0,ins(0,1,7,8),    0,0,0,5,6,  "d2_a"));
        vecs.push_back(mk(0,1,0,ins(0,5,1,6),    0,0,0,7,8,  "d2_b"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,1,0,1,6,  "d2_prio"));
        vecs.push_back(mk(0,1,0,ins(8,0,2,0),    0,0,0,0,0,  "r0_lw"));
        vecs.push_back(mk(0,1,0,ins(0,3,0,0),    0,0,0,2,0,  "r0_nostall"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,0,0,0,0,  "r0_nofwd"));
        vecs.push_back(mk(0,1,0,ins(8,1,2,0),    0,0,0,0,0,  "fl_lw"));
        vecs.push_back(mk(0,1,1,ins(0,3,1,1),    0,0,0,2,0,  "fl_nostall"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,0,0,0,0,  "fl_bubble"));
        vecs.push_back(mk(0,1,0,ins(13,0,0,0),   0,0,0,0,0,  "call"));
        vecs.push_back(mk(0,1,0,ins(14,0,0,0),   0,0,0,0,0,  "ret"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,1,0,15,0, "ret_fwd"));
        vecs.push_back(mk(0,1,0,ins(8,7,2,0),    0,0,0,0,0,  "sw_lw"));
        vecs.push_back(mk(0,1,0,ins(9,7,2,0),    1,0,0,2,0,  "sw_stall"));
        vecs.push_back(mk(0,1,0,ins(9,7,2,0),    0,0,0,0,0,  "sw_bubble"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,0,2,2,7,  "sw_fwd"));
        vecs.push_back(mk(0,1,0,ins(0,9,1,2),    0,0,0,0,0,  "lhb_pre"));
        vecs.push_back(mk(0,1,0,ins(10,9,3,4),   0,0,0,1,2,  "lhb"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,1,0,9,0,  "lhb_fwd"));
        vecs.push_back(mk(0,1,0,ins(8,5,5,0),    0,0,0,0,0,  "llb_lw"));
        vecs.push_back(mk(0,1,0,ins(11,6,5,5),   0,0,0,5,0,  "llb_nostall"));
        vecs.push_back(mk(0,0,0,16'h0000,        0,0,0,0,0,  "llb_src"));

        // Reset landing in the middle of a load-use stall.
        hand.push_back(mk(0,1,0,ins(8,1,2,0),    0,0,0,0,0,  "rs_lw"));
        hand.push_back(mk(1,1,0,ins(0,3,1,4),    1,0,0,2,0,  "rs_stall"));
        hand.push_back(mk(0,1,0,ins(0,3,1,4),    0,0,0,0,0,  "rs_clear"));
        hand.push_back(mk(0,0,0,16'h0000,        0,0,0,1,4,  "rs_wiped"));

        rst          = 1'b1;
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.id_instr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) runStep(vecs[i]);
        for (int i = 0; i < hand.size(); i++) runStep(hand[i]);

        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
